// File: rtl/joy_pkg.sv
// Shared types and constants for the joystick serial scan controller:
// FSM state encoding, default chain length and button bit positions.
package joy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } joy_fsm_e;

    localparam int JOY_NBITS = 16;

    localparam int JOY1_UP    = 7;
    localparam int JOY1_DOWN  = 6;
    localparam int JOY1_LEFT  = 5;
    localparam int JOY1_RIGHT = 4;
    localparam int JOY1_FIRE1 = 3;
    localparam int JOY1_FIRE2 = 2;

    localparam int JOY2_UP    = JOY1_UP    + 8;
    localparam int JOY2_DOWN  = JOY1_DOWN  + 8;
    localparam int JOY2_LEFT  = JOY1_LEFT  + 8;
    localparam int JOY2_RIGHT = JOY1_RIGHT + 8;
    localparam int JOY2_FIRE1 = JOY1_FIRE1 + 8;
    localparam int JOY2_FIRE2 = JOY1_FIRE2 + 8;

endpackage

// File: rtl/joy_scan_ctrl_if.sv
// Scan request / chain / result bundle between a host and joy_scan_ctrl.
// The controller takes the slave side; the host (or bench) takes the master side.
interface joy_scan_ctrl_if
    import joy_pkg::*;
#(
    parameter int NBITS = JOY_NBITS
) ();

    logic             scan_req;
    logic             sync_en;
    logic             hsync;
    logic             joy_data;
    logic             joy_clk;
    logic             joy_load_n;
    logic             busy;
    logic [NBITS-1:0] joy_state;
    logic             joy_valid;
    logic             joy_changed;

    modport master (
        output scan_req, sync_en, hsync, joy_data,
        input  joy_clk, joy_load_n, busy, joy_state, joy_valid, joy_changed
    );

    modport slave (
        input  scan_req, sync_en, hsync, joy_data,
        output joy_clk, joy_load_n, busy, joy_state, joy_valid, joy_changed
    );

endinterface

// File: rtl/joy_sync_edge.sv
// Two-flop synchronizer for an asynchronous level plus a registered
// falling-edge pulse; the pulse appears three cycles after the input falls.
module joy_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic fall
);

    logic s1_r;
    logic s2_r;
    logic prev_r;
    logic fall_r;

    // synchronizer chain, history flop and registered edge pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_r   <= 1'b1;
            s2_r   <= 1'b1;
            prev_r <= 1'b1;
            fall_r <= 1'b0;
        end else begin
            s1_r   <= async_in;
            s2_r   <= s1_r;
            prev_r <= s2_r;
            fall_r <= prev_r & ~s2_r;
        end
    end

    assign fall = fall_r;

endmodule

// File: rtl/joy_scan_ctrl.sv
// Serial joystick scanner: loads an external shift-register chain, clocks
// NBITS bits in, and publishes the word with valid/changed pulses.
module joy_scan_ctrl
    import joy_pkg::*;
#(
    parameter int HALF  = 2,
    parameter int NBITS = JOY_NBITS,
    parameter int AUTO  = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    joy_scan_ctrl_if.slave bus
);

    localparam int CW = $clog2(HALF + 1);
    localparam int BW = $clog2(NBITS + 1);

    localparam logic [CW-1:0] CNT_RLD   = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic          AUTO_TRIG = (AUTO != 0) ? 1'b1 : 1'b0;

    joy_fsm_e         state_r;
    joy_fsm_e         state_next;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_next;
    logic             ph_r;
    logic             ph_next;
    logic [BW-1:0]    bit_r;
    logic [BW-1:0]    bit_next;
    logic             pend_r;
    logic             pend_next;
    logic             sample_s;
    logic             fall_s;
    logic             ext_trig_s;
    logic [NBITS-1:0] shreg_r;
    logic [NBITS-1:0] shin_s;

    logic             joy_clk_r;
    logic             joy_load_n_r;
    logic             busy_r;
    logic             valid_r;
    logic             changed_r;
    logic [NBITS-1:0] joy_state_r;

    joy_sync_edge u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (bus.hsync),
        .fall     (fall_s)
    );

    assign ext_trig_s = bus.scan_req | (bus.sync_en & fall_s) | AUTO_TRIG;

    // next sample enters at the top so the first bit ends up in bit 0
    always_comb begin
        shin_s             = shreg_r >> 1'b1;
        shin_s[NBITS-1]    = bus.joy_data;
    end

    // next-state, half-period/bit counters and pending-trigger logic
    always_comb begin
        state_next = state_r;
        cnt_next   = cnt_r;
        ph_next    = ph_r;
        bit_next   = bit_r;
        pend_next  = pend_r;
        sample_s   = 1'b0;

        if ((state_r != ST_IDLE) && ext_trig_s) begin
            pend_next = 1'b1;
        end else begin
            pend_next = pend_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (ext_trig_s || pend_r) begin
                    state_next = ST_LOAD;
                    cnt_next   = CNT_RLD;
                    ph_next    = 1'b0;
                    pend_next  = 1'b0;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // load strobe spans two half-periods, both with joy_clk low
                if (cnt_r != '0) begin
                    cnt_next = cnt_r - CNT_ONE;
                end else if (!ph_r) begin
                    cnt_next = CNT_RLD;
                    ph_next  = 1'b1;
                end else begin
                    state_next = ST_SHIFT;
                    cnt_next   = CNT_RLD;
                    ph_next    = 1'b0;
                    bit_next   = '0;
                end
            end
            ST_SHIFT: begin
                if (cnt_r != '0) begin
                    cnt_next = cnt_r - CNT_ONE;
                end else if (!ph_r) begin
                    sample_s = 1'b1;
                    cnt_next = CNT_RLD;
                    ph_next  = 1'b1;
                end else if (bit_r == BIT_LAST) begin
                    state_next = ST_DONE;
                    cnt_next   = CNT_RLD;
                    ph_next    = 1'b0;
                end else begin
                    cnt_next = CNT_RLD;
                    ph_next  = 1'b0;
                    bit_next = bit_r + BIT_ONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM, counters and sample shift register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            ph_r    <= 1'b0;
            bit_r   <= '0;
            pend_r  <= 1'b0;
            shreg_r <= '1;
        end else begin
            state_r <= state_next;
            cnt_r   <= cnt_next;
            ph_r    <= ph_next;
            bit_r   <= bit_next;
            pend_r  <= pend_next;
            if (sample_s) begin
                shreg_r <= shin_s;
            end
        end
    end

    // outputs registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            joy_clk_r    <= 1'b0;
            joy_load_n_r <= 1'b1;
            busy_r       <= 1'b0;
            valid_r      <= 1'b0;
            changed_r    <= 1'b0;
            joy_state_r  <= '1;
        end else begin
            joy_clk_r    <= (state_next == ST_SHIFT) & ph_next;
            joy_load_n_r <= (state_next != ST_LOAD);
            busy_r       <= (state_next != ST_IDLE);
            valid_r      <= (state_next == ST_DONE);
            if (state_next == ST_DONE) begin
                joy_state_r <= shreg_r;
                changed_r   <= (shreg_r != joy_state_r);
            end else begin
                changed_r   <= 1'b0;
            end
        end
    end

    assign bus.joy_clk     = joy_clk_r;
    assign bus.joy_load_n  = joy_load_n_r;
    assign bus.busy        = busy_r;
    assign bus.joy_valid   = valid_r;
    assign bus.joy_changed = changed_r;
    assign bus.joy_state   = joy_state_r;

endmodule

// File: doc/joy_scan_ctrl.md
JOY_SCAN_CTRL -- requirements
Module: joy_scan_ctrl

Interface
REQ-001 Parameter HALF, default 2: clk cycles per joy_clk half-period; bit period T = 2*HALF; legal range 1..255.
REQ-002 Parameter NBITS, default 16: number of serial bits per scan; legal range 1..32.
REQ-003 Parameter AUTO, default 0: 1 = free-running scans, 0 = scans only on trigger.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst_n  in  1  reset; synchronous and active-low.
REQ-006 scan_req  in  1  single-cycle scan request.
REQ-007 sync_en  in  1  1 = a falling edge of hsync also triggers a scan.
REQ-008 hsync  in  1  asynchronous line sync; synchronized internally.
REQ-009 joy_data  in  1  serial data from the shift-register chain.
REQ-010 joy_clk  out  1  shift clock to the chain; registered.
REQ-011 joy_load_n  out  1  parallel-load strobe to the chain, active-low; registered.
REQ-012 busy  out  1  high from LOAD entry until DONE exit.
REQ-013 joy_state  out  NBITS  last completed scan; bit i = i-th serial bit; active-low buttons.
REQ-014 joy_valid  out  1  one-cycle pulse when joy_state updates.
REQ-015 joy_changed  out  1  one-cycle pulse, coincident with joy_valid, when the new joy_state differs from the previous value.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, SHIFT and DONE.
REQ-017 Trigger SHALL be scan_req OR (sync_en AND synchronized hsync falling edge) OR AUTO OR pending.
REQ-018 In IDLE, a trigger at cycle t SHALL enter LOAD at t+1.
REQ-019 In LOAD: joy_load_n=0 and joy_clk=0 for exactly T cycles; then SHIFT.
REQ-020 In SHIFT, each bit period SHALL be HALF cycles with joy_clk=0, then HALF cycles with joy_clk=1; joy_load_n=1.
REQ-021 joy_data SHALL be sampled in the last cycle of each joy_clk-low half; the k-th sample (k=0..NBITS-1) goes to joy_state bit k.
REQ-022 After NBITS bit periods, the FSM SHALL enter DONE at cycle t+1+T*(NBITS+1); with the defaults this is t+69.
REQ-023 DONE SHALL last 1 cycle, with joy_state updated, joy_valid=1, joy_changed as in REQ-015 and joy_clk=0; the next state is IDLE.
REQ-024 A trigger arriving while busy SHALL set a one-deep pending flag; further triggers while pending is set are merged.
REQ-025 pending SHALL clear when the next LOAD is entered, so back-to-back scans are separated by exactly one IDLE cycle.
REQ-026 Simultaneous scan_req and hsync edge SHALL produce one scan.
REQ-027 A trigger in the DONE cycle SHALL set pending.
REQ-028 Samples SHALL accumulate in an internal shift register; joy_state SHALL change only on DONE entry, never mid-scan.
REQ-029 With AUTO=1, IDLE SHALL always last 1 cycle; scan_req and hsync have no extra effect.
REQ-030 The hsync synchronizer SHALL be 2 flip-flops followed by an edge register; the edge is detected 3 cycles after the hsync transition.
REQ-031 The bit-period counter SHALL be ceil(log2(HALF+1)) bits wide and reload at the start of each half-period; it SHALL never wrap.
REQ-032 The bit counter SHALL be ceil(log2(NBITS+1)) bits wide.

Reset
REQ-033 While rst_n=0 at posedge clk, outputs SHALL be: joy_state all ones, joy_load_n=1, joy_clk=0, busy=0, joy_valid=0, joy_changed=0.
REQ-034 While rst_n=0 at posedge clk: pending=0, synchronizer flops=1, FSM=IDLE.
REQ-035 Reset mid-scan SHALL abort the scan with no joy_valid and joy_state forced to all ones; the first trigger after release starts a fresh LOAD.

Structure
REQ-036 Package joy_pkg SHALL hold the state enum, the default NBITS and the button bit indices.
REQ-037 Button bit indices: JOY1_UP=7, JOY1_DOWN=6, JOY1_LEFT=5, JOY1_RIGHT=4, JOY1_FIRE1=3, JOY1_FIRE2=2, JOY2_* = JOY1_* + 8.
REQ-038 The synchronizer and falling-edge detector SHALL be one sub-module, joy_sync_edge; all other logic is flat.

Verification
REQ-039 Defaults, scan_req pulse at cycle 10 -> joy_load_n low cycles 11-14; 16 joy_clk high pulses; joy_valid at cycle 79 only.
REQ-040 Chain model serializing 16'hA5F0 (bit0 first) -> joy_state=16'hA5F0 and joy_changed=1; an identical rescan -> joy_valid=1, joy_changed=0.
REQ-041 scan_req pulsed 3 times during a busy scan -> exactly one extra scan, starting with LOAD 2 cycles after the first DONE.
REQ-042 sync_en=1, hsync falls at cycle 0 -> LOAD at cycle 4; with sync_en=0 -> no scan.
REQ-043 rst_n low for 1 cycle in SHIFT bit 8 -> no joy_valid, joy_state=16'hFFFF, joy_load_n=1, busy=0 next cycle.
REQ-044 AUTO=1, HALF=1, NBITS=4 -> joy_valid every 12 cycles (T=2: 10-cycle scan + 1 DONE + 1 IDLE), with no stall.
